ws2812_stream: RTL
==================

WS2812_STREAM -- requirements
Module: ws2812_stream

Interface
REQ-001 SHALL have parameter LED_COUNT, default 8, number of pixels per frame (>=1).
REQ-002 SHALL have parameter T_BIT, default 63, clk cycles per bit period (>=3).
REQ-003 SHALL have parameter T0H, default 20, dout-high cycles for a 0 bit.
REQ-004 SHALL have parameter T1H, default 40, dout-high cycles for a 1 bit; 0 < T0H < T1H < T_BIT.
REQ-005 SHALL have parameter T_LATCH, default 15000, dout-low reset/latch cycles after the last bit.
REQ-006 SHALL have parameter COLOR_ORDER, default 0, with 0 = GRB on wire and 1 = RGB on wire.
REQ-007 SHALL define ADDR_W = max(1, clog2(LED_COUNT)).
REQ-008 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-009 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-010 SHALL have port start, input, 1, single-cycle frame request.
REQ-011 SHALL have port auto_refresh, input, 1, level; restarts a frame immediately after latch.
REQ-012 SHALL have port brightness, input, 8, global scale, sampled at each pixel capture.
REQ-013 SHALL have port pix_rd, output, 1, single-cycle pixel read strobe.
REQ-014 SHALL have port pix_addr, output, ADDR_W, pixel index, valid while pix_rd=1.
REQ-015 SHALL have port pix_data, input, 24, pixel as {R,G,B}, valid exactly one cycle after pix_rd.
REQ-016 SHALL have port dout, output, 1, WS2812 serial line.
REQ-017 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-018 SHALL have port frame_done, output, 1, one-cycle pulse on the final LATCH cycle.

Function
REQ-019 SHALL implement the states IDLE, FETCH, LOAD, SEND and LATCH.
REQ-020 IDLE: on start=1, SHALL go to FETCH next cycle; start SHALL be ignored in all other states.
REQ-021 FETCH: for one cycle, SHALL drive pix_rd=1 and pix_addr=0, then go to LOAD.
REQ-022 LOAD: SHALL capture pix_data (scaled and reordered) into the shift register, then go to SEND; dout rises on the first SEND cycle, three cycles after start.
REQ-023 Scaling: each 8-bit channel c SHALL become (c*(brightness+1))>>8, with a 16-bit intermediate; brightness=255 is identity and brightness=0 gives 0.
REQ-024 Reorder: the wire word SHALL be {G,R,B} when COLOR_ORDER=0 and {R,G,B} when COLOR_ORDER=1, sent MSB first, 24 bits per pixel.
REQ-025 Bit timing: each bit SHALL last exactly T_BIT cycles, with dout=1 for the first T1H (1 bit) or T0H (0 bit) cycles and 0 for the remainder.
REQ-026 Prefetch: for pixel n < LED_COUNT-1, SHALL pulse pix_rd with pix_addr=n+1 in the first cycle of that pixel's last bit, capture the result next cycle into a holding register, and load it at the next pixel boundary.
REQ-027 The prefetch SHALL leave zero idle cycles between pixels, and no prefetch SHALL occur for the last pixel.
REQ-028 pix_rd SHALL pulse exactly LED_COUNT times per frame, with addresses 0..LED_COUNT-1 ascending.
REQ-029 After the last bit of the last pixel, SHALL enter LATCH with dout=0 for exactly T_LATCH cycles and pulse frame_done on the final LATCH cycle.
REQ-030 After LATCH, SHALL go to FETCH if auto_refresh=1 (busy stays 1), else to IDLE.
REQ-031 Start asserted on the frame_done cycle SHALL be ignored; start is accepted from IDLE only.
REQ-032 brightness changes mid-pixel SHALL NOT affect the pixel already loaded.

Reset
REQ-033 While reset=1, SHALL hold state=IDLE, dout=0, busy=0, pix_rd=0, pix_addr=0, frame_done=0 and cleared bit/pixel counters, asynchronously.
REQ-034 Reset mid-frame SHALL abort with no frame_done; the next start SHALL begin again at address 0.

Verification (LED_COUNT=3, T_BIT=10, T0H=3, T1H=6, T_LATCH=20)
REQ-035 GRB, brightness=255, pixels 0xFF0000/0x00FF00/0x0000FF, start at cycle 0 -> wire words 0x00FF00, 0xFF0000, 0x0000FF; high pulses of 6 or 3 cycles; first rise at cycle 3; frame_done at cycle 3+720+19=742.
REQ-036 brightness=128, pixel 0xFF8001, COLOR_ORDER=0 -> wire word 0x408000; with COLOR_ORDER=1 -> 0x804000.
REQ-037 Full frame -> bit periods contiguous, every rising edge 10 cycles apart across pixel boundaries; pix_rd exactly 3 pulses, addresses 0,1,2.
REQ-038 auto_refresh=1 -> pix_rd with addr 0 in the cycle after frame_done; busy never drops.
REQ-039 reset asserted during bit 5 of pixel 1 -> dout=0 and busy=0 immediately; a later start produces a complete frame from addr 0 with one frame_done.
REQ-040 start pulsed during SEND and on the frame_done cycle -> ignored; busy falls, one frame only.

Source files
------------

// File: rtl/ws2812_stream.sv
// WS2812 pixel streamer: fetches 24-bit {R,G,B} pixels from an external store,
// applies a global brightness scale and emits the serial bit stream and latch gap.
module ws2812_stream #(
  parameter int LED_COUNT   = 8,
  parameter int T_BIT       = 63,
  parameter int T0H         = 20,
  parameter int T1H         = 40,
  parameter int T_LATCH     = 15000,
  parameter int COLOR_ORDER = 0,
  parameter int ADDR_W      = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              auto_refresh,
  input  logic [7:0]        brightness,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  output logic              dout,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = $clog2(T_BIT);
  localparam int LW = (T_LATCH > 1) ? $clog2(T_LATCH) : 1;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(LED_COUNT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, LATCH} state_t;

  state_t             state, next;
  logic [CW-1:0]      cyc;
  logic [4:0]         bit_idx;
  logic [ADDR_W-1:0]  pix_idx;
  logic [LW-1:0]      lat_cnt;
  logic [23:0]        sh, hold;
  logic               pf_pend;
  logic               bit_end, pix_end, last_pix, lat_end, pf_rd;

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    return 8'((16'(c) * (16'(b) + 16'd1)) >> 8);
  endfunction

  function automatic logic [23:0] wire_word(input logic [23:0] px, input logic [7:0] b);
    logic [7:0] r, g, bl;
    r  = scale(px[23:16], b);
    g  = scale(px[15:8], b);
    bl = scale(px[7:0], b);
    return (COLOR_ORDER == 0) ? {g, r, bl} : {r, g, bl};
  endfunction

  assign bit_end  = (cyc == CW'(T_BIT - 1));
  assign pix_end  = bit_end && (bit_idx == 5'd23);
  assign last_pix = (pix_idx == LAST_PIX);
  assign lat_end  = (lat_cnt == LW'(T_LATCH - 1));
  // Next pixel is requested at the start of the last bit so it is ready at the boundary.
  assign pf_rd    = (state == SEND) && (bit_idx == 5'd23) && (cyc == '0) && !last_pix;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = FETCH;
      FETCH:   next = LOAD;
      LOAD:    next = SEND;
      SEND:    if (pix_end && last_pix) next = LATCH;
      LATCH:   if (lat_end) next = auto_refresh ? FETCH : IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    dout       = 1'b0;
    pix_rd     = 1'b0;
    pix_addr   = '0;
    frame_done = (state == LATCH) && lat_end;
    if (state == SEND)
      dout = (cyc < (sh[23] ? CW'(T1H) : CW'(T0H)));
    if (state == FETCH) begin
      pix_rd = 1'b1;
    end else if (pf_rd) begin
      pix_rd   = 1'b1;
      pix_addr = pix_idx + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc     <= '0;
      bit_idx <= '0;
      pix_idx <= '0;
      lat_cnt <= '0;
      sh      <= '0;
      hold    <= '0;
      pf_pend <= 1'b0;
    end else begin
      pf_pend <= pf_rd;
      // Brightness is sampled here, so later changes only hit later pixels.
      if (pf_pend) hold <= wire_word(pix_data, brightness);
      case (state)
        FETCH: begin
          cyc     <= '0;
          bit_idx <= '0;
          pix_idx <= '0;
          lat_cnt <= '0;
        end
        LOAD: begin
          sh      <= wire_word(pix_data, brightness);
          cyc     <= '0;
          bit_idx <= '0;
        end
        SEND: begin
          if (bit_end) begin
            cyc <= '0;
            if (bit_idx == 5'd23) begin
              bit_idx <= '0;
              sh      <= hold;
              lat_cnt <= '0;
              if (!last_pix) pix_idx <= pix_idx + ADDR_W'(1);
            end else begin
              bit_idx <= bit_idx + 5'd1;
              sh      <= {sh[22:0], 1'b0};
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        LATCH: lat_cnt <= lat_end ? '0 : lat_cnt + LW'(1);
        default: ;
      endcase
    end
  end

endmodule
